cdc_loopback_fifo: RTL and testbench
====================================

Name: cdc_loopback_fifo

Overview:
- Parametrised byte-stream processor between the usb_cdc OUT (host->device) and IN (device->host) bulk streams of the SoC.
- Buffers received bytes in a DEPTH-entry FIFO and applies a selectable per-byte transform: pass, increment, case-swap or to-upper.
- Releases the buffered bytes to the IN stream in bursts, on a fill threshold, an idle timeout or an explicit flush.
- Successor to the fixed loopback used on TinyFPGA-BX: width of buffer, burst policy and transform are now configurable.

Parameters:
- DEPTH, 16, FIFO entries; power of 2, minimum 2.
- THRESHOLD, 8, FIFO count that triggers a drain; 1..DEPTH.
- TIMEOUT, 1000, idle clk cycles in COLLECT before a forced drain; >=1.
- CNT_W, 16, width of the optional statistics counters.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous active-high reset.
- out_data_i  in  8  byte from usb_cdc OUT endpoint.
- out_valid_i  in  1  out_data_i valid.
- out_ready_o  out  1  block accepts the byte.
- in_data_o  out  8  byte to usb_cdc IN endpoint.
- in_valid_o  out  1  in_data_o valid.
- in_ready_i  in  1  usb_cdc accepts the byte.
- mode_i  in  2  transform: 0 pass, 1 +1 mod 256, 2 swap case (A-Z<->a-z), 3 to-upper (a-z -> A-Z).
- flush_i  in  1  one-cycle pulse; forces drain of the buffered bytes.
- level_o  out  $clog2(DEPTH)+1  current FIFO count.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset values:
  - count, pointers and timer = 0; state = IDLE.
  - in_valid_o = 0, in_data_o = 0, level_o = 0.
  - out_ready_o reads 1 during reset, but no push is taken while rst_i is high.
- Push: happens when out_valid_i & out_ready_o, with out_ready_o = (count != DEPTH).
  - The byte is transformed using mode_i sampled in the same cycle.
  - It is written at wr_ptr; the pointer wraps modulo DEPTH.
  - Transforms are purely per-byte. Non-letter bytes are unchanged in modes 2 and 3. Mode 1 wraps 8'hFF -> 8'h00.
- Pop: happens when in_valid_o & in_ready_i. rd_ptr advances and wraps modulo DEPTH.
  - in_data_o = mem[rd_ptr], first-word fall-through.
  - in_data_o must hold stable while in_valid_o=1 and in_ready_i=0.
- Simultaneous push and pop: count unchanged. On a full FIFO, a pop frees the slot combinationally only in the next cycle; out_ready_o is not a function of in_ready_i.
- State machine (registered):
  - IDLE: in_valid_o=0. Goes to COLLECT when count becomes nonzero.
  - COLLECT: in_valid_o=0; timer increments each cycle and clears on every push.
    - -> DRAIN when any of: count >= THRESHOLD, timer == TIMEOUT-1, flush_i=1.
    - Priority is irrelevant; any condition wins.
  - DRAIN: in_valid_o = (count != 0). Pushes continue to be accepted.
    - -> IDLE when count == 0 and no push in that cycle.
    - -> COLLECT when count == 0 and a push occurs in that cycle.
    - The timer is cleared on leaving DRAIN.
- flush_i in IDLE with count==0: ignored. flush_i in DRAIN: no effect.
- Latency: a byte pushed in cycle N with THRESHOLD=1 and state IDLE produces in_valid_o=1 at cycle N+2 (count updates at N+1, state at N+2).
- Full: with count==DEPTH, out_ready_o=0. No byte is dropped or overwritten.
- Reset mid-operation: all buffered data is discarded immediately and outputs return to reset values asynchronously.
- level_o = count, registered.

Optional Feature:
- Macro: CDC_LOOPBACK_STATS_EN.
- When defined, the block adds:
  - ports rx_count_o[CNT_W-1:0], counting pushes;
  - tx_count_o[CNT_W-1:0], counting pops;
  - ovf_count_o[CNT_W-1:0], counting cycles with out_valid_i=1 & out_ready_o=0.
- All three counters saturate at all-ones, reset to 0 and are cleared by flush_i.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- mode 0, THRESHOLD=8: push 8'h01..8'h07, idle for TIMEOUT cycles -> no in_valid_o before the timeout; then 01..07 in order; state returns to IDLE.
- mode 1: push "12345678" (8 bytes) -> drain triggers on the 8th byte; output "23456789"; 8'hFF maps to 8'h00.
- mode 2: push "ABCDEFGH" and "QRSTUVWX" with in_ready_i held 0 -> accepts exactly 16 bytes; out_ready_o=0 with level_o=16. Releasing in_ready_i yields "abcdefgh" then "qrstuvwx" with no loss.
- Backpressure: toggle in_ready_i every cycle during drain while pushing concurrently -> the output sequence equals the input sequence; in_data_o stays stable while stalled.
- flush_i pulse after 3 bytes (THRESHOLD=8) -> in_valid_o within 2 cycles; 3 bytes out. flush_i with an empty FIFO -> stays IDLE.
- Assert rst_i during DRAIN with 5 bytes buffered -> in_valid_o=0 and level_o=0 immediately. A following push of 8'h42 (mode 3) is output as 8'h42.

Source files
------------

// File: rtl/cdc_loopback_fifo.sv
// Byte-stream loopback between usb_cdc OUT and IN: FIFO buffer, per-byte transform, burst release.
// Optional statistics counters are built when CDC_LOOPBACK_STATS_EN is defined.
module cdc_loopback_fifo #(
  parameter int DEPTH     = 16,
  parameter int THRESHOLD = 8,
  parameter int TIMEOUT   = 1000,
  parameter int CNT_W     = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [7:0]               out_data_i,
  input  logic                     out_valid_i,
  output logic                     out_ready_o,
  output logic [7:0]               in_data_o,
  output logic                     in_valid_o,
  input  logic                     in_ready_i,
  input  logic [1:0]               mode_i,
  input  logic                     flush_i,
  output logic [$clog2(DEPTH):0]   level_o
`ifdef CDC_LOOPBACK_STATS_EN
  ,
  output logic [CNT_W-1:0]         rx_count_o,
  output logic [CNT_W-1:0]         tx_count_o,
  output logic [CNT_W-1:0]         ovf_count_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_nxt;
  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [7:0]    xf_data;
  logic          push;
  logic          pop;
  logic          drain_cond;
  logic          is_upper;
  logic          is_lower;

  // Ready depends only on the registered count, so a pop frees space one cycle later.
  assign out_ready_o = (count != LW'(DEPTH));
  assign push        = out_valid_i & out_ready_o & ~rst_i;
  assign in_valid_o  = (state == ST_DRAIN) && (count != '0);
  assign pop         = in_valid_o & in_ready_i;
  assign in_data_o   = in_valid_o ? mem[rd_ptr] : 8'h00;
  assign level_o     = count;

  assign is_upper = (out_data_i >= 8'h41) && (out_data_i <= 8'h5A);
  assign is_lower = (out_data_i >= 8'h61) && (out_data_i <= 8'h7A);

  always_comb begin
    xf_data = out_data_i;
    case (mode_i)
      2'd1: xf_data = out_data_i + 8'd1;
      2'd2: begin
        if (is_upper)      xf_data = out_data_i | 8'h20;
        else if (is_lower) xf_data = out_data_i & 8'hDF;
      end
      2'd3: begin
        if (is_lower) xf_data = out_data_i & 8'hDF;
      end
      default: xf_data = out_data_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= xf_data;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  assign drain_cond = (count >= LW'(THRESHOLD)) || (timer == TW'(TIMEOUT - 1)) || flush_i;

  // IDLE may jump straight to DRAIN so a threshold of 1 releases data two cycles after the push.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    case (state)
      ST_IDLE: begin
        timer_nxt = '0;
        if (count != '0) state_nxt = drain_cond ? ST_DRAIN : ST_COLLECT;
      end
      ST_COLLECT: begin
        timer_nxt = push ? '0 : timer + TW'(1);
        if (drain_cond) begin
          state_nxt = ST_DRAIN;
          timer_nxt = '0;
        end
      end
      ST_DRAIN: begin
        timer_nxt = '0;
        if (count == '0) state_nxt = push ? ST_COLLECT : ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        timer_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      timer <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
    end
  end

`ifdef CDC_LOOPBACK_STATS_EN
  // Saturating counters; a flush pulse clears them alongside forcing a drain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_count_o  <= '0;
      tx_count_o  <= '0;
      ovf_count_o <= '0;
    end else if (flush_i) begin
      rx_count_o  <= '0;
      tx_count_o  <= '0;
      ovf_count_o <= '0;
    end else begin
      if (push && (rx_count_o != '1)) rx_count_o <= rx_count_o + CNT_W'(1);
      if (pop && (tx_count_o != '1))  tx_count_o <= tx_count_o + CNT_W'(1);
      if (out_valid_i && !out_ready_o && (ovf_count_o != '1))
        ovf_count_o <= ovf_count_o + CNT_W'(1);
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_cdc_loopback_fifo.sv
// Scoreboard bench for cdc_loopback_fifo: randomized byte traffic against a queue-based reference.
module tb_cdc_loopback_fifo;

  localparam int DEPTH     = 16;
  localparam int THRESHOLD = 8;
  localparam int TIMEOUT   = 50;
  localparam int LW        = $clog2(DEPTH) + 1;

  logic          clk_i;
  logic          rst_i;
  logic [7:0]    out_data_i;
  logic          out_valid_i;
  logic          out_ready_o;
  logic [7:0]    in_data_o;
  logic          in_valid_o;
  logic          in_ready_i;
  logic [1:0]    mode_i;
  logic          flush_i;
  logic [LW-1:0] level_o;

  int         n_compared;
  int         n_mismatched;
  logic [7:0] exp_q[$];
  int         model_count;
  logic       prev_stall;
  logic [7:0] prev_data;

  cdc_loopback_fifo #(
    .DEPTH(DEPTH), .THRESHOLD(THRESHOLD), .TIMEOUT(TIMEOUT), .CNT_W(16)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .out_data_i(out_data_i), .out_valid_i(out_valid_i), .out_ready_o(out_ready_o),
    .in_data_o(in_data_o), .in_valid_o(in_valid_o), .in_ready_i(in_ready_i),
    .mode_i(mode_i), .flush_i(flush_i), .level_o(level_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference transform written from the character rules with plain integer arithmetic.
  function automatic logic [7:0] ref_xform(input logic [7:0] b, input logic [1:0] m);
    int v;
    v = int'(b);
    case (m)
      2'd1: v = (v + 1) % 256;
      2'd2: begin
        if (v >= 65 && v <= 90)       v = v + 32;
        else if (v >= 97 && v <= 122) v = v - 32;
      end
      2'd3: if (v >= 97 && v <= 122) v = v - 32;
      default: v = v;
    endcase
    return 8'(v);
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_compared++;
    n_mismatched++;
    $display("[TB] FAIL %s: bound expired, got no event, expected one at %0t", name, $time);
  endtask

  // Monitor: records accepted bytes into the scoreboard and checks every released byte.
  always @(negedge clk_i) begin
    logic [7:0] exp_b;
    if (rst_i) begin
      exp_q.delete();
      model_count = 0;
      prev_stall  = 1'b0;
    end else begin
      check_output("level", 32'(level_o), 32'(model_count));
      check_output("out_ready", 32'(out_ready_o), 32'(model_count != DEPTH));
      if (prev_stall) begin
        check_output("stall_valid", 32'(in_valid_o), 32'd1);
        check_output("stall_data", 32'(in_data_o), 32'(prev_data));
      end
      if (in_valid_o && in_ready_i) begin
        if (exp_q.size() == 0) begin
          n_compared++;
          n_mismatched++;
          $display("[TB] FAIL unexpected_out: got %0h, expected no byte", in_data_o);
        end else begin
          exp_b = exp_q.pop_front();
          check_output("in_data", 32'(in_data_o), 32'(exp_b));
        end
        model_count--;
      end
      if (out_valid_i && out_ready_o) begin
        exp_q.push_back(ref_xform(out_data_i, mode_i));
        model_count++;
      end
      prev_stall = in_valid_o && !in_ready_i;
      prev_data  = in_data_o;
    end
  end

  task automatic apply_stimulus(input logic [7:0] d, input logic [1:0] m);
    int n;
    n = 0;
    out_data_i  = d;
    mode_i      = m;
    out_valid_i = 1'b1;
    while (!out_ready_o && n < 200) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (n >= 200) timeout_fail("push_wait");
    @(posedge clk_i); #1;
    out_valid_i = 1'b0;
  endtask

  task automatic pulse_flush();
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n;
    n = 0;
    while (!in_valid_o && n < budget) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (!in_valid_o) timeout_fail(name);
  endtask

  task automatic wait_drained(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || level_o != '0) && n < budget) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (n >= budget) timeout_fail("drain_wait");
    check_output("drained_level", 32'(level_o), 32'd0);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] str_a [8];
    logic [7:0] str_b [8];
    n_compared   = 0;
    n_mismatched = 0;
    model_count  = 0;
    prev_stall   = 1'b0;
    rst_i        = 1'b1;
    out_data_i   = 8'h55;
    out_valid_i  = 1'b1;
    in_ready_i   = 1'b1;
    mode_i       = 2'd0;
    flush_i      = 1'b0;

    #1;
    check_output("rst_in_valid", 32'(in_valid_o), 32'd0);
    check_output("rst_in_data", 32'(in_data_o), 32'd0);
    check_output("rst_level", 32'(level_o), 32'd0);
    check_output("rst_out_ready", 32'(out_ready_o), 32'd1);
    repeat (3) @(posedge clk_i);
    #1 out_valid_i = 1'b0;
    #1 rst_i = 1'b0;
    @(posedge clk_i); #1;

    $display("[TB] mode 0 timeout drain");
    for (int i = 1; i <= 7; i++) apply_stimulus(8'(i), 2'd0);
    for (int i = 1; i < TIMEOUT; i++) begin
      check_output("no_early_valid", 32'(in_valid_o), 32'd0);
      @(posedge clk_i); #1;
    end
    wait_valid("timeout_drain", 5);
    wait_drained(100);
    repeat (3) @(posedge clk_i);
    #1 check_output("idle_after_drain", 32'(in_valid_o), 32'd0);

    $display("[TB] mode 1 threshold drain and wrap");
    for (int i = 0; i < 8; i++) apply_stimulus(8'h31 + 8'(i), 2'd1);
    wait_valid("threshold_drain", 2);
    wait_drained(100);
    apply_stimulus(8'hFF, 2'd1);
    pulse_flush();
    wait_valid("wrap_flush", 2);
    wait_drained(100);

    $display("[TB] mode 2 full buffer");
    str_a = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48};
    str_b = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h58};
    in_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) apply_stimulus(str_a[i], 2'd2);
    for (int i = 0; i < 8; i++) apply_stimulus(str_b[i], 2'd2);
    out_data_i  = 8'h5A;
    out_valid_i = 1'b1;
    repeat (3) begin
      @(posedge clk_i); #1;
      check_output("full_ready", 32'(out_ready_o), 32'd0);
      check_output("full_level", 32'(level_o), 32'(DEPTH));
    end
    out_valid_i = 1'b0;
    in_ready_i  = 1'b1;
    wait_drained(100);

    $display("[TB] backpressure with concurrent random pushes");
    in_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) apply_stimulus(8'($urandom), 2'($urandom));
    for (int i = 0; i < 80; i++) begin
      in_ready_i  = ~in_ready_i;
      out_valid_i = 1'($urandom_range(0, 1));
      out_data_i  = 8'($urandom);
      mode_i      = 2'($urandom);
      @(posedge clk_i); #1;
    end
    out_valid_i = 1'b0;
    in_ready_i  = 1'b1;
    wait_drained(200);

    $display("[TB] flush behaviour");
    for (int i = 0; i < 3; i++) apply_stimulus(8'($urandom), 2'($urandom));
    pulse_flush();
    check_output("flush_valid", 32'(in_valid_o), 32'd1);
    wait_drained(100);
    repeat (3) @(posedge clk_i);
    #1 pulse_flush();
    repeat (4) begin
      check_output("empty_flush_valid", 32'(in_valid_o), 32'd0);
      @(posedge clk_i); #1;
    end

    $display("[TB] reset during drain");
    in_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) apply_stimulus(8'h30 + 8'(i), 2'd0);
    pulse_flush();
    check_output("pre_reset_valid", 32'(in_valid_o), 32'd1);
    @(posedge clk_i); #2;
    rst_i = 1'b1;
    #1;
    check_output("midrst_in_valid", 32'(in_valid_o), 32'd0);
    check_output("midrst_level", 32'(level_o), 32'd0);
    check_output("midrst_in_data", 32'(in_data_o), 32'd0);
    @(negedge clk_i);
    @(posedge clk_i); #2;
    rst_i      = 1'b0;
    in_ready_i = 1'b1;
    @(posedge clk_i); #1;
    apply_stimulus(8'h42, 2'd3);
    apply_stimulus(8'h61, 2'd3);
    pulse_flush();
    wait_valid("post_reset_drain", 2);
    wait_drained(100);

    repeat (3) @(posedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
